adam_fabric_pause_seq: RTL and testbench

Ordered pause/resume sequencer for the low-speed fabric domain. One upstream pause handshake fans out to N downstream pause handshakes, such as the LSPA and LSPB peripheral fabrics and then the lsdom crossbar. Children are paused one at a time in ascending index order and resumed in descending order, so no fabric stage is paused while a downstream stage can still issue traffic into it. A per-step watchdog flags a child that never acknowledges.

---
 rtl/adam_fabric_pkg.sv | 17 +
 rtl/adam_fabric_pause_wdog.sv | 33 +++
 rtl/adam_fabric_pause_seq.sv | 158 +++++++++++++++
 tb/tb_adam_fabric_pause_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adam_fabric_pkg.sv
// Shared types for the fabric pause sequencers: sequencer state and index sizing.
package adam_fabric_pkg;

  typedef enum logic [2:0] {
    SETTLE,
    RUNNING,
    PAUSING,
    PAUSED,
    RESUMING
  } pause_seq_state_t;

  // Width needed to index n children; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adam_fabric_pause_wdog.sv
// Step watchdog: counts cycles since the last restart, pulses o_expired on the cycle the
// count reaches TIMEOUT (once per wait; TIMEOUT=0 never expires). No backpressure.
module adam_fabric_pause_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at TIMEOUT so the expiry pulse fires only once per wait.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(TIMEOUT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign o_expired = 1'b0;
    end else begin : g_enabled
      assign o_expired = !i_restart && (r_cnt == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/adam_fabric_pause_seq.sv
// Ordered pause/resume fan-out: pauses children 0..N-1 in order, resumes N-1..0, one req/ack
// step at a time (2N+1 edges with 1-cycle children); waits indefinitely on slow acks, watchdog flags.
module adam_fabric_pause_seq
  import adam_fabric_pkg::*;
#(
  parameter int NO_CHILDREN = 3,
  parameter int TIMEOUT     = 1024,
  parameter int IDX_WIDTH   = idx_width(NO_CHILDREN)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_up_req,
  output logic                   o_up_ack,
  output logic [NO_CHILDREN-1:0] o_ch_req,
  input  logic [NO_CHILDREN-1:0] i_ch_ack,
  output logic                   o_timeout,
  output logic [IDX_WIDTH-1:0]   o_timeout_idx,
  input  logic                   i_timeout_clr,
  output logic                   o_busy
);

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NO_CHILDREN - 1);

  pause_seq_state_t       r_state;
  logic [IDX_WIDTH-1:0]   r_idx;
  logic [NO_CHILDREN-1:0] r_ch_req;
  logic                   r_up_ack;
  logic                   r_busy;
  logic                   r_timeout;
  logic [IDX_WIDTH-1:0]   r_timeout_idx;

  logic                   w_ack_cur;
  logic                   w_step;
  logic                   w_expired;
  logic [IDX_WIDTH-1:0]   w_first_nack;

  assign w_ack_cur = i_ch_ack[r_idx];

  // A step is any edge where state, idx or the targeted ch_req moves.
  always_comb begin
    w_step = 1'b0;
    case (r_state)
      SETTLE:   w_step = &i_ch_ack;
      PAUSING:  w_step = w_ack_cur;
      RESUMING: w_step = !w_ack_cur;
      PAUSED:   w_step = !i_up_req;
      RUNNING:  w_step = i_up_req;
      default:  w_step = 1'b0;
    endcase
  end

  always_comb begin
    w_first_nack = '0;
    for (int i = NO_CHILDREN - 1; i >= 0; i--) begin
      if (!i_ch_ack[i]) w_first_nack = IDX_WIDTH'(i);
    end
  end

  adam_fabric_pause_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (w_step || !r_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= SETTLE;
      r_idx         <= '0;
      r_ch_req      <= '1;
      r_up_ack      <= 1'b0;
      r_busy        <= 1'b1;
      r_timeout     <= 1'b0;
      r_timeout_idx <= '0;
    end else begin
      if (i_timeout_clr) begin
        r_timeout     <= 1'b0;
        r_timeout_idx <= '0;
      end else if (w_expired && !r_timeout) begin
        r_timeout     <= 1'b1;
        r_timeout_idx <= (r_state == SETTLE) ? w_first_nack : r_idx;
      end

      case (r_state)
        SETTLE: begin
          if (&i_ch_ack) begin
            r_state  <= PAUSED;
            r_up_ack <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        PAUSED: begin
          if (!i_up_req) begin
            r_state        <= RESUMING;
            r_busy         <= 1'b1;
            r_idx          <= LAST;
            r_ch_req[LAST] <= 1'b0;
          end
        end
        RESUMING: begin
          // A pending reversal turns around on the child that just finished.
          if (!w_ack_cur) begin
            if (i_up_req) begin
              r_state         <= PAUSING;
              r_ch_req[r_idx] <= 1'b1;
            end else if (r_idx == '0) begin
              r_state  <= RUNNING;
              r_up_ack <= 1'b0;
              r_busy   <= 1'b0;
            end else begin
              r_idx                            <= r_idx - IDX_WIDTH'(1);
              r_ch_req[r_idx - IDX_WIDTH'(1)]  <= 1'b0;
            end
          end
        end
        RUNNING: begin
          if (i_up_req) begin
            r_state     <= PAUSING;
            r_busy      <= 1'b1;
            r_idx       <= '0;
            r_ch_req[0] <= 1'b1;
          end
        end
        PAUSING: begin
          if (w_ack_cur) begin
            if (!i_up_req) begin
              r_state         <= RESUMING;
              r_ch_req[r_idx] <= 1'b0;
            end else if (r_idx == LAST) begin
              r_state  <= PAUSED;
              r_up_ack <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_idx                            <= r_idx + IDX_WIDTH'(1);
              r_ch_req[r_idx + IDX_WIDTH'(1)]  <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= SETTLE;
          r_idx    <= '0;
          r_ch_req <= '1;
          r_up_ack <= 1'b0;
          r_busy   <= 1'b1;
        end
      endcase
    end
  end

  assign o_up_ack      = r_up_ack;
  assign o_ch_req      = r_ch_req;
  assign o_busy        = r_busy;
  assign o_timeout     = r_timeout;
  assign o_timeout_idx = r_timeout_idx;

endmodule

// File: tb/tb_adam_fabric_pause_seq.sv
// Bench for adam_fabric_pause_seq with N=3 behavioural children (held, fixed or random ack latency).
module tb_adam_fabric_pause_seq;

  localparam int N  = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         up_req;
  logic         timeout_clr;
  logic         up_ack;
  logic         timeout;
  logic         busy;
  logic [N-1:0] ch_req;
  logic [N-1:0] ch_ack = '0;
  logic [1:0]   timeout_idx;

  logic [N-1:0] hold = '1;
  bit           rand_lat = 1'b0;
  int           cnt [N];

  int total = 0;
  int bad   = 0;

  adam_fabric_pause_seq #(
    .NO_CHILDREN (N),
    .TIMEOUT     (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_up_req      (up_req),
    .o_up_ack      (up_ack),
    .o_ch_req      (ch_req),
    .i_ch_ack      (ch_ack),
    .o_timeout     (timeout),
    .o_timeout_idx (timeout_idx),
    .i_timeout_clr (timeout_clr),
    .o_busy        (busy)
  );

  // Child fabrics: ack follows req one edge after the extra delay in cnt[i] expires.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && ch_ack[i] != ch_req[i]) begin
        if (cnt[i] <= 0) ch_ack[i] <= ch_req[i];
        else             cnt[i] <= cnt[i] - 1;
      end else if (ch_ack[i] == ch_req[i]) begin
        cnt[i] <= rand_lat ? int'($urandom_range(20, 0)) : 0;
      end
    end
  end

  function automatic logic [N-1:0] thermo(input int ones);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (i < ones) v[i] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (ch_req !== 3'b111) begin bad++; $display("FAIL reset_ch_req got=%b want=111", ch_req); end
    total++; if (up_ack !== 1'b0) begin bad++; $display("FAIL reset_up_ack got=%b want=0", up_ack); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
    total++; if (timeout !== 1'b0 || timeout_idx !== 2'd0) begin
      bad++; $display("FAIL reset_timeout got=%b/%0d want=0/0", timeout, timeout_idx);
    end
    rst_n = 1'b1;
    hold  = '0;
    @(negedge clk);
    total++; if (up_ack !== 1'b0) begin bad++; $display("FAIL settle_edge1_up_ack got=%b want=0", up_ack); end
    @(negedge clk);
    total++; if (up_ack !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL settle_done got up_ack=%b busy=%b want 1/0", up_ack, busy);
    end
  endtask

  task automatic test_resume_pause();
    up_req = 1'b0;
    for (int k = 1; k <= 2*N+1; k++) begin
      @(negedge clk);
      total++; if (ch_req !== thermo(N - (k+1)/2)) begin
        bad++; $display("FAIL resume_ch_req edge=%0d got=%b want=%b", k, ch_req, thermo(N - (k+1)/2));
      end
      total++; if (up_ack !== (k < 2*N+1)) begin
        bad++; $display("FAIL resume_up_ack edge=%0d got=%b want=%b", k, up_ack, (k < 2*N+1));
      end
    end
    up_req = 1'b1;
    for (int k = 1; k <= 2*N+1; k++) begin
      @(negedge clk);
      total++; if (ch_req !== thermo((k+1)/2)) begin
        bad++; $display("FAIL pause_ch_req edge=%0d got=%b want=%b", k, ch_req, thermo((k+1)/2));
      end
      total++; if (up_ack !== (k >= 2*N+1)) begin
        bad++; $display("FAIL pause_up_ack edge=%0d got=%b want=%b", k, up_ack, (k >= 2*N+1));
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pause_busy got=%b want=0", busy); end
  endtask

  task automatic test_reversal();
    logic [N-1:0] prev_req, prev_ack;
    logic [N-1:0] seen [$];
    up_req = 1'b0;
    for (int c = 0; c < 40 && !(up_ack === 1'b0 && busy === 1'b0); c++) @(negedge clk);
    total++; if (up_ack !== 1'b0) begin bad++; $display("FAIL rev_to_running got up_ack=%b want=0", up_ack); end
    hold[1] = 1'b1;
    up_req  = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (ch_req !== 3'b011 || busy !== 1'b1) begin
      bad++; $display("FAIL rev_waiting got ch_req=%b busy=%b want 011/1", ch_req, busy);
    end
    up_req  = 1'b0;
    hold[1] = 1'b0;
    prev_req = ch_req;
    prev_ack = ch_ack;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      total++; if ($countones(ch_req ^ prev_req) > 1) begin
        bad++; $display("FAIL rev_multi_toggle got=%b prev=%b", ch_req, prev_req);
      end
      if (ch_req !== prev_req) begin
        if (seen.size() == 0) begin
          total++; if (prev_ack[1] !== 1'b1) begin
            bad++; $display("FAIL rev_before_ack1 got ack1=%b want=1", prev_ack[1]);
          end
        end
        seen.push_back(ch_req);
      end
      prev_req = ch_req;
      prev_ack = ch_ack;
    end
    total++; if (seen.size() != 2 || seen[0] !== 3'b001 || seen[1] !== 3'b000) begin
      bad++; $display("FAIL rev_sequence got %0d changes first=%b want 2 changes 001,000",
                      seen.size(), (seen.size() > 0) ? seen[0] : 3'bxxx);
    end
    total++; if (up_ack !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rev_final got up_ack=%b busy=%b want 0/0", up_ack, busy);
    end
  endtask

  task automatic test_timeout();
    int t2, tt;
    t2 = -1;
    tt = -1;
    hold[2] = 1'b1;
    up_req  = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (ch_req[2] === 1'b1 && t2 < 0) t2 = c;
      if (timeout === 1'b1 && tt < 0) tt = c;
      if (c == 40) hold[2] = 1'b0;
      if (up_ack === 1'b1) break;
    end
    total++; if (t2 < 0 || tt < 0 || tt - t2 != TO) begin
      bad++; $display("FAIL wdog_delay got req2@%0d timeout@%0d want gap=%0d", t2, tt, TO);
    end
    total++; if (timeout_idx !== 2'd2) begin bad++; $display("FAIL wdog_idx got=%0d want=2", timeout_idx); end
    total++; if (up_ack !== 1'b1 || timeout !== 1'b1) begin
      bad++; $display("FAIL wdog_late_ack got up_ack=%b timeout=%b want 1/1", up_ack, timeout);
    end
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    total++; if (timeout !== 1'b0 || timeout_idx !== 2'd0) begin
      bad++; $display("FAIL wdog_clear got=%b/%0d want=0/0", timeout, timeout_idx);
    end
  endtask

  task automatic test_mid_reset();
    up_req = 1'b0;
    for (int c = 0; c < 20 && ch_req !== 3'b001; c++) @(negedge clk);
    total++; if (ch_req !== 3'b001 || up_ack !== 1'b1) begin
      bad++; $display("FAIL midrst_setup got ch_req=%b up_ack=%b want 001/1", ch_req, up_ack);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (ch_req !== 3'b111 || up_ack !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL midrst_values got ch_req=%b up_ack=%b busy=%b want 111/0/1", ch_req, up_ack, busy);
    end
    up_req = 1'b1;
    for (int c = 0; c < 40 && up_ack !== 1'b1; c++) @(negedge clk);
    total++; if (up_ack !== 1'b1 || busy !== 1'b0 || ch_req !== 3'b111) begin
      bad++; $display("FAIL midrst_resettle got up_ack=%b busy=%b ch_req=%b want 1/0/111", up_ack, busy, ch_req);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] prev_req, prev_ack, want;
    logic         prev_up;
    int           toggles, acks;
    rand_lat = 1'b1;
    toggles  = 0;
    acks     = 0;
    prev_req = ch_req;
    prev_ack = ch_ack;
    prev_up  = up_ack;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      total++; if ($countones(ch_req ^ prev_req) > 1) begin
        bad++; $display("FAIL rnd_multi_toggle cyc=%0d got=%b prev=%b", c, ch_req, prev_req);
      end
      total++; if (((ch_req ^ prev_req) & (prev_req ^ prev_ack)) != '0) begin
        bad++; $display("FAIL rnd_req_before_ack cyc=%0d req=%b prev_req=%b prev_ack=%b", c, ch_req, prev_req, prev_ack);
      end
      total++; if ((ch_req & (ch_req + N'(1))) != '0) begin
        bad++; $display("FAIL rnd_order cyc=%0d got=%b want thermometer", c, ch_req);
      end
      if (up_ack !== prev_up) begin
        acks++;
        want = up_ack ? '1 : '0;
        total++; if (up_ack !== up_req || ch_req !== want || ch_ack !== want) begin
          bad++; $display("FAIL rnd_up_ack cyc=%0d up_ack=%b up_req=%b ch_req=%b ch_ack=%b want all %b",
                          c, up_ack, up_req, ch_req, ch_ack, up_ack);
        end
      end
      prev_req = ch_req;
      prev_ack = ch_ack;
      prev_up  = up_ack;
      if (up_req === up_ack && $urandom_range(3, 0) == 0) begin
        up_req = ~up_req;
        toggles++;
      end
    end
    for (int c = 0; c < 500 && up_ack !== up_req; c++) begin
      @(negedge clk);
      if (up_ack !== prev_up) acks++;
      prev_up = up_ack;
    end
    total++; if (up_ack !== up_req || acks != toggles) begin
      bad++; $display("FAIL rnd_handshakes got up_ack=%b acks=%0d want up_ack=%b acks=%0d", up_ack, acks, up_req, toggles);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    up_req      = 1'b1;
    timeout_clr = 1'b0;
    test_reset();
    test_resume_pause();
    test_reversal();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
